// File: rtl/config_loader_pkg.sv
// Shared types and header field layout for the configuration frame loader.
package config_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4
  } state_e;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned HDR_FLAG = 31;
  localparam int unsigned BURST_HI = 29;
  localparam int unsigned BURST_LO = 24;
  localparam int unsigned COL_HI   = 15;
  localparam int unsigned COL_LO   = 8;
  localparam int unsigned FRM_HI   = 7;
  localparam int unsigned FRM_LO   = 0;

  localparam int unsigned COL_W    = COL_HI - COL_LO + 1;
  localparam int unsigned FRM_W    = FRM_HI - FRM_LO + 1;
  localparam int unsigned BURST_W  = BURST_HI - BURST_LO + 1;

endpackage

// File: rtl/config_frame_loader_if.sv
// Config word stream (valid/ready) between the bitstream front end and the loader.
interface config_frame_loader_if;
  import config_loader_pkg::*;

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/config_frame_loader_strobe_dec.sv
// One-hot latch-enable decoder: line col*FRAMES_PER_COL+frame, all zero when disabled.
module frame_strobe_decoder #(
  parameter int unsigned NUM_COLUMNS    = 16,
  parameter int unsigned FRAMES_PER_COL = 20
) (
  input  logic [7:0]                              col_i,
  input  logic [7:0]                              frame_i,
  input  logic                                    en_i,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]   onehot_c
);

  localparam int unsigned NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;

  logic [31:0] idx_c;

  assign idx_c = 32'(col_i) * 32'(FRAMES_PER_COL) + 32'(frame_i);

  for (genvar g = 0; g < NUM_STROBES; g++) begin : g_dec
    assign onehot_c[g] = en_i && (idx_c == 32'(g));
  end

endmodule

// File: rtl/config_frame_loader.sv
// Config frame loader: header/data word pairs become setup/strobe/hold writes into latch columns.
// Build option CONFIG_FRAME_LOADER_BURST_EN enables multi-frame bursts from header bits 29:24.
module config_frame_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned FRAME_BITS     = 32,
  parameter int unsigned NUM_COLUMNS    = 16,
  parameter int unsigned FRAMES_PER_COL = 20,
  parameter int unsigned STROBE_CYCLES  = 2
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  config_frame_loader_if.slave                   s,
  input  logic                                   err_clr,
  output logic [FRAME_BITS-1:0]                  FrameData,
  output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0]  FrameStrobe,
  output logic                                   busy,
  output logic                                   err
);

  localparam int unsigned NUM_STROBES = NUM_COLUMNS * FRAMES_PER_COL;
  localparam int unsigned CNT_W       = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [FRM_W-1:0]        frm_q, frm_d;
  logic [FRAME_BITS-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [NUM_STROBES-1:0]  strobe_q, strobe_c;
`ifdef CONFIG_FRAME_LOADER_BURST_EN
  logic [BURST_W-1:0]      left_q, left_d;
`endif

  logic                    ready_c;
  logic                    accept_c;
  logic                    hdr_ok_c;
  logic                    err_set_c;
  logic                    strobe_en_c;
  logic [COL_W-1:0]        hdr_col_c;
  logic [FRM_W-1:0]        hdr_frm_c;

  assign ready_c   = (state_q == IDLE) || (state_q == WAIT_DATA);
  assign accept_c  = s.s_valid && ready_c;
  assign hdr_col_c = s.s_data[COL_HI:COL_LO];
  assign hdr_frm_c = s.s_data[FRM_HI:FRM_LO];
  assign hdr_ok_c  = s.s_data[HDR_FLAG]
                  && ({1'b0, hdr_col_c} < 9'(NUM_COLUMNS))
                  && ({1'b0, hdr_frm_c} < 9'(FRAMES_PER_COL));

  // Next state, write sequencing and error detection.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    frm_d     = frm_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    err_set_c = 1'b0;
`ifdef CONFIG_FRAME_LOADER_BURST_EN
    left_d    = left_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (hdr_ok_c) begin
            col_d   = hdr_col_c;
            frm_d   = hdr_frm_c;
`ifdef CONFIG_FRAME_LOADER_BURST_EN
            left_d  = s.s_data[BURST_HI:BURST_LO];
`endif
            state_d = WAIT_DATA;
          end else begin
            err_set_c = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (accept_c) begin
          data_d  = FRAME_BITS'(s.s_data);
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
`ifdef CONFIG_FRAME_LOADER_BURST_EN
        if (left_q == '0) begin
          state_d = IDLE;
        end else begin
          left_d  = left_q - 1'b1;
          state_d = WAIT_DATA;
          if (frm_q == FRM_W'(FRAMES_PER_COL - 1)) begin
            frm_d = '0;
            if (col_q == COL_W'(NUM_COLUMNS - 1)) begin
              err_set_c = 1'b1;
              state_d   = IDLE;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    err_d       = err_set_c | (err_q & ~err_clr);
    strobe_en_c = (state_d == STROBE);
  end

  frame_strobe_decoder #(
    .NUM_COLUMNS    (NUM_COLUMNS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) u_dec (
    .col_i    (col_d),
    .frame_i  (frm_d),
    .en_i     (strobe_en_c),
    .onehot_c (strobe_c)
  );

  // Strobe is registered so the latch enables never carry decode glitches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      col_q    <= '0;
      frm_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      strobe_q <= '0;
`ifdef CONFIG_FRAME_LOADER_BURST_EN
      left_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      frm_q    <= frm_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      strobe_q <= strobe_c;
`ifdef CONFIG_FRAME_LOADER_BURST_EN
      left_q   <= left_d;
`endif
    end
  end

  assign s.s_ready   = ready_c;
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule
